// File: rtl/reg_bank_pkg.sv
// Shared definitions for the TD-series register bank: program-counter opcodes
// as seen by the instruction decoder.
package reg_bank_pkg;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [1:0] {
        PC_INC  = OP_INC,
        PC_JMP  = OP_JMP,
        PC_CALL = OP_CALL,
        PC_RET  = OP_RET
    } pc_op_t;

endpackage

// File: rtl/reg_bank_ret_stack.sv
// LIFO return-address stack for CALL/RET; push is ignored when full, pop when empty.
// Only instantiated when REG_BANK_STACK_EN is defined.
module ret_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0]   sp;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge CLK) begin
        if (CLR)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SPW'(1);
        else if (pop && !empty)
            sp <= sp - SPW'(1);
    end

    // Entry storage carries no reset: clearing sp is enough to discard it.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++)
            if (push && !full && sp == SPW'(i))
                mem[i] <= din;
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sp == SPW'(i + 1))
                top = mem[i];
    end

endmodule

// File: rtl/reg_bank.sv
// TD-series register bank: general registers, program counter and C/Z flags.
// Define REG_BANK_STACK_EN to add the hardware return-address stack for CALL/RET.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NREGS       = 2,
    parameter int PC_WIDTH    = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       EN,
    input  logic                       WE,
    input  logic [$clog2(NREGS)-1:0]   WSEL,
    input  logic [WIDTH-1:0]           WDATA,
    input  logic [$clog2(NREGS)-1:0]   RSEL_A,
    input  logic [$clog2(NREGS)-1:0]   RSEL_B,
    output logic [WIDTH-1:0]           RDATA_A,
    output logic [WIDTH-1:0]           RDATA_B,
    input  logic [1:0]                 PC_OP,
    input  logic [PC_WIDTH-1:0]        PC_IM,
    output logic [PC_WIDTH-1:0]        PC,
    input  logic                       FLAG_WE,
    input  logic                       CARRY_IN,
    output logic                       C_FLAG,
    output logic                       Z_FLAG,
    output logic                       STK_FULL,
    output logic                       STK_EMPTY,
    output logic                       STK_ERR
);
    localparam int SEL_W = $clog2(NREGS);

    logic [WIDTH-1:0]    regs [NREGS];
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                c_q;
    logic                z_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (EN && WE) begin
            for (int i = 0; i < NREGS; i++)
                if (WSEL == SEL_W'(i))
                    regs[i] <= WDATA;
        end
    end

    // Out-of-range selects match no entry and read back as zero.
    always_comb begin
        RDATA_A = '0;
        RDATA_B = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (RSEL_A == SEL_W'(i)) RDATA_A = regs[i];
            if (RSEL_B == SEL_W'(i)) RDATA_B = regs[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else if (EN && FLAG_WE) begin
            c_q <= CARRY_IN;
            z_q <= (WDATA == '0);
        end
    end

    assign C_FLAG = c_q;
    assign Z_FLAG = z_q;
    assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef REG_BANK_STACK_EN
    logic                stk_push;
    logic                stk_pop;
    logic                stk_err_set;
    logic                stk_err_q;
    logic [PC_WIDTH-1:0] stk_top;
    logic                stk_full;
    logic                stk_empty;
`endif

    always_comb begin
        pc_nxt = pc_inc;
`ifdef REG_BANK_STACK_EN
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_err_set = 1'b0;
`endif
        case (pc_op_t'(PC_OP))
            PC_INC: pc_nxt = pc_inc;
            PC_JMP: pc_nxt = PC_IM;
            PC_CALL: begin
                pc_nxt = PC_IM;
`ifdef REG_BANK_STACK_EN
                if (stk_full) stk_err_set = 1'b1;
                else          stk_push    = EN;
`endif
            end
            PC_RET: begin
                pc_nxt = pc_inc;
`ifdef REG_BANK_STACK_EN
                if (stk_empty) begin
                    stk_err_set = 1'b1;
                end else begin
                    pc_nxt  = stk_top;
                    stk_pop = EN;
                end
`endif
            end
            default: pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR)
            pc_q <= '0;
        else if (EN)
            pc_q <= pc_nxt;
    end

    assign PC = pc_q;

`ifdef REG_BANK_STACK_EN
    ret_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Sticky until reset so software can poll after a burst of calls.
    always_ff @(posedge CLK) begin
        if (CLR)
            stk_err_q <= 1'b0;
        else if (EN && stk_err_set)
            stk_err_q <= 1'b1;
    end

    assign STK_FULL  = stk_full;
    assign STK_EMPTY = stk_empty;
    assign STK_ERR   = stk_err_q;
`else
    assign STK_FULL  = 1'b0;
    assign STK_EMPTY = 1'b1;
    assign STK_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed scoreboard bench for reg_bank; expectations follow REG_BANK_STACK_EN.
module tb_reg_bank;
    localparam int WIDTH       = 4;
    localparam int NREGS       = 2;
    localparam int PC_WIDTH    = 4;
    localparam int STACK_DEPTH = 4;

    logic                CLK = 1'b0;
    logic                CLR, EN, WE, FLAG_WE, CARRY_IN;
    logic [0:0]          WSEL, RSEL_A, RSEL_B;
    logic [WIDTH-1:0]    WDATA, RDATA_A, RDATA_B;
    logic [1:0]          PC_OP;
    logic [PC_WIDTH-1:0] PC_IM, PC;
    logic                C_FLAG, Z_FLAG, STK_FULL, STK_EMPTY, STK_ERR;

    reg_bank #(
        .WIDTH(WIDTH), .NREGS(NREGS), .PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .WE(WE), .WSEL(WSEL), .WDATA(WDATA),
        .RSEL_A(RSEL_A), .RSEL_B(RSEL_B), .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
        .PC_OP(PC_OP), .PC_IM(PC_IM), .PC(PC), .FLAG_WE(FLAG_WE), .CARRY_IN(CARRY_IN),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  pc_m;
    logic [3:0]  stk_m[$];
    logic        err_m;

    task automatic expv(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] sample(input string tag);
        if (tag == "PC")    return 16'(PC);
        if (tag == "RDA")   return 16'(RDATA_A);
        if (tag == "RDB")   return 16'(RDATA_B);
        if (tag == "C")     return 16'(C_FLAG);
        if (tag == "Z")     return 16'(Z_FLAG);
        if (tag == "EMPTY") return 16'(STK_EMPTY);
        if (tag == "FULL")  return 16'(STK_FULL);
        if (tag == "ERR")   return 16'(STK_ERR);
        return 16'hxxxx;
    endfunction

    task automatic drain();
        exp_t        e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = sample(e.tag);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Drives one PC operation, advances the reference model, then checks after the edge.
    task automatic step_pc(input logic [1:0] op, input logic [3:0] im);
        PC_OP = op;
        PC_IM = im;
        if (CLR) begin
            pc_m  = 4'h0;
            stk_m.delete();
            err_m = 1'b0;
        end else if (EN) begin
            case (op)
                2'b00: pc_m = pc_m + 4'd1;
                2'b01: pc_m = im;
                2'b10: begin
`ifdef REG_BANK_STACK_EN
                    if (stk_m.size() == STACK_DEPTH) err_m = 1'b1;
                    else stk_m.push_back(pc_m + 4'd1);
`endif
                    pc_m = im;
                end
                default: begin
`ifdef REG_BANK_STACK_EN
                    if (stk_m.size() == 0) begin
                        err_m = 1'b1;
                        pc_m  = pc_m + 4'd1;
                    end else begin
                        pc_m = stk_m.pop_back();
                    end
`else
                    pc_m = pc_m + 4'd1;
`endif
                end
            endcase
        end
        expv("PC", 16'(pc_m));
        expv("EMPTY", 16'(stk_m.size() == 0));
        expv("FULL", 16'(stk_m.size() == STACK_DEPTH));
        expv("ERR", 16'(err_m));
        tick();
        drain();
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        expv("RDA", 16'h0);
        expv("RDB", 16'h0);
        expv("C", 16'h0);
        expv("Z", 16'h0);
        step_pc(2'b00, 4'h0);
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; EN = 1'b1; WE = 1'b0; FLAG_WE = 1'b0; CARRY_IN = 1'b0;
        WSEL = '0; RSEL_A = '0; RSEL_B = 1'b1; WDATA = '0; PC_OP = 2'b00; PC_IM = '0;
        pc_m = '0; err_m = 1'b0;
        @(negedge CLK);
        do_clr();

        // Preload registers, flags and PC, then reset
        WE = 1'b1; WSEL = 1'b0; WDATA = 4'h5;
        expv("RDA", 16'h5);
        step_pc(2'b00, 4'h0);
        WSEL = 1'b1; WDATA = 4'h3; FLAG_WE = 1'b1; CARRY_IN = 1'b1;
        expv("RDB", 16'h3);
        expv("C", 16'h1);
        expv("Z", 16'h0);
        step_pc(2'b01, 4'h7);
        WE = 1'b0; FLAG_WE = 1'b0; CARRY_IN = 1'b0;
        do_clr();

        // Write with same-cycle read of the same register
        WE = 1'b1; WSEL = 1'b1; WDATA = 4'hA; RSEL_A = 1'b1;
        #1;
        expv("RDA", 16'h0);
        drain();
        expv("RDA", 16'hA);
        step_pc(2'b00, 4'h0);
        WE = 1'b0;

        // Global enable low holds everything
        EN = 1'b0; WE = 1'b1; WDATA = 4'h3; FLAG_WE = 1'b1; CARRY_IN = 1'b1;
        expv("RDA", 16'hA);
        expv("C", 16'h0);
        expv("Z", 16'h0);
        step_pc(2'b01, 4'h9);
        EN = 1'b1; WE = 1'b0; FLAG_WE = 1'b0; CARRY_IN = 1'b0;

        // Flags: set, hold, clear alongside a register write
        FLAG_WE = 1'b1; CARRY_IN = 1'b1; WDATA = 4'h0;
        expv("C", 16'h1);
        expv("Z", 16'h1);
        step_pc(2'b00, 4'h0);
        FLAG_WE = 1'b0; CARRY_IN = 1'b0; WDATA = 4'h5;
        expv("C", 16'h1);
        expv("Z", 16'h1);
        step_pc(2'b00, 4'h0);
        FLAG_WE = 1'b1; WDATA = 4'h7; WE = 1'b1; WSEL = 1'b0; RSEL_B = 1'b0;
        expv("C", 16'h0);
        expv("Z", 16'h0);
        expv("RDB", 16'h7);
        expv("RDA", 16'hA);
        step_pc(2'b00, 4'h0);
        FLAG_WE = 1'b0; WE = 1'b0;

        // PC wrap and jump
        step_pc(2'b01, 4'hF);
        step_pc(2'b00, 4'h0);
        step_pc(2'b01, 4'h5);

        // Nested calls and returns
        step_pc(2'b01, 4'h2);
        step_pc(2'b10, 4'h8);
        step_pc(2'b10, 4'hC);
        step_pc(2'b11, 4'h0);
        step_pc(2'b11, 4'h0);

        // Overflow then underflow; error stays sticky until reset
        for (int i = 1; i <= 5; i++)
            step_pc(2'b10, 4'(i));
        for (int i = 0; i < 5; i++)
            step_pc(2'b11, 4'h0);
        step_pc(2'b00, 4'h0);
        do_clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
